// File: rtl/stroke_pkg.sv
// Shared types and defaults for the stroke sequencer.
// Segment layout, default coordinate limits and the issue FSM states.
package stroke_pkg;

  localparam int XMAX_DEF = 639;
  localparam int YMAX_DEF = 479;

  // One queued line segment (x0,y0)->(x1,y1), 38 bits.
  typedef struct packed {
    logic [9:0] x0;
    logic [8:0] y0;
    logic [9:0] x1;
    logic [8:0] y1;
  } segment_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

endpackage

// File: rtl/seg_fifo.sv
// Synchronous segment FIFO. The head entry is presented combinationally and
// is valid whenever the FIFO is non-empty. The caller only pushes when there
// is room (or when a pop in the same cycle frees a slot).
module seg_fifo
  import stroke_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic                   pop,
  input  segment_t               wr_data,
  output segment_t               rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  segment_t        mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic [AW:0]     count_next;

  // Storage write; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= wr_data;
  end

  // Occupancy follows push/pop on the same edge.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // Pointer and count registers; pointers wrap naturally since DEPTH is 2^n.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;

endmodule

// File: rtl/stroke_sequencer.sv
// Stroke sequencer: turns mouse samples + pen state into queued line
// segments and hands them one at a time to the line drawer via ld_start /
// ld_done. Optional macro STROKE_DEDUP_EN suppresses zero-length segments
// produced by a repeated pen-down position.
module stroke_sequencer
  import stroke_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int XMAX  = XMAX_DEF,
  parameter int YMAX  = YMAX_DEF
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   sample_valid,
  input  logic [9:0]             sample_x,
  input  logic [8:0]             sample_y,
  input  logic                   pen_down,
  input  logic                   clear_ovf,
  output logic                   ld_start,
  output logic [9:0]             ld_x0,
  output logic [8:0]             ld_y0,
  output logic [9:0]             ld_x1,
  output logic [8:0]             ld_y1,
  input  logic                   ld_done,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);

  logic [9:0] cx;
  logic [8:0] cy;
  logic [9:0] last_x_reg;
  logic [8:0] last_y_reg;
  logic       have_last_reg;
  logic       overflow_reg;
  logic       push_try;
  logic       push_ok;
  logic       drop;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  segment_t   new_seg;
  segment_t   head_seg;
  segment_t   ld_seg_reg;
  logic       ld_start_reg;
  logic       latch_en;
  state_t     state_reg;
  state_t     state_next;

  // Clamp first so every comparison and stored value is in range.
  assign cx = (sample_x > 10'(XMAX)) ? 10'(XMAX) : sample_x;
  assign cy = (sample_y > 9'(YMAX))  ? 9'(YMAX)  : sample_y;

`ifdef STROKE_DEDUP_EN
  assign push_try = sample_valid && pen_down &&
                    !(have_last_reg && (cx == last_x_reg) && (cy == last_y_reg));
`else
  assign push_try = sample_valid && pen_down;
`endif

  // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
  assign fifo_pop = (state_reg == S_WAIT) && ld_done;
  assign push_ok  = push_try && (!fifo_full || fifo_pop);
  assign drop     = push_try && !push_ok;

  // First point of a stroke is a dot; later points continue from the last accepted endpoint.
  always_comb begin
    new_seg.x0 = have_last_reg ? last_x_reg : cx;
    new_seg.y0 = have_last_reg ? last_y_reg : cy;
    new_seg.x1 = cx;
    new_seg.y1 = cy;
  end

  seg_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push    (push_ok),
    .pop     (fifo_pop),
    .wr_data (new_seg),
    .rd_data (head_seg),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Stroke tracking and sticky overflow; a dropped segment leaves last untouched.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_x_reg    <= '0;
      last_y_reg    <= '0;
      have_last_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      if (sample_valid && !pen_down) begin
        have_last_reg <= 1'b0;
      end else if (push_ok) begin
        have_last_reg <= 1'b1;
        last_x_reg    <= cx;
        last_y_reg    <= cy;
      end
      if (drop)           overflow_reg <= 1'b1;
      else if (clear_ovf) overflow_reg <= 1'b0;
    end
  end

  // Issue FSM next-state: latch head, pulse start, wait for done.
  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (!fifo_empty) begin
          latch_en   = 1'b1;
          state_next = S_START;
        end
      end
      S_START: state_next = S_WAIT;
      S_WAIT:  if (ld_done) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM state, endpoint hold registers and the registered start pulse.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg    <= S_IDLE;
      ld_seg_reg   <= '0;
      ld_start_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ld_start_reg <= (state_reg == S_START);
      if (latch_en) ld_seg_reg <= head_seg;
    end
  end

  assign ld_start = ld_start_reg;
  assign ld_x0    = ld_seg_reg.x0;
  assign ld_y0    = ld_seg_reg.y0;
  assign ld_x1    = ld_seg_reg.x1;
  assign ld_y1    = ld_seg_reg.y1;
  assign overflow = overflow_reg;
  assign busy     = !fifo_empty || (state_reg != S_IDLE);

endmodule
